// File: rtl/cnt_bank_pkg.sv
// Shared definitions for the counter bank: mode encoding and the
// start/terminal value helpers used by every channel.
package cnt_bank_pkg;

    // Counting mode of one channel.
    typedef enum logic [1:0] {
        CNT_MODE_WRAP    = 2'd0,
        CNT_MODE_SAT     = 2'd1,
        CNT_MODE_ONESHOT = 2'd2,
        CNT_MODE_DOWN    = 2'd3
    } cnt_mode_e;

    // Widest counter the helpers below can serve; callers cast to their width.
    localparam int CNT_WIDTH_MAX = 32;

    // Value a channel restarts from: limit when counting down, zero otherwise.
    function automatic logic [CNT_WIDTH_MAX-1:0] start_value(
        input cnt_mode_e                mode,
        input logic [CNT_WIDTH_MAX-1:0] limit
    );
        return (mode == CNT_MODE_DOWN) ? limit : '0;
    endfunction

    // Value at which a channel is considered at its end: zero when counting
    // down, limit otherwise.
    function automatic logic [CNT_WIDTH_MAX-1:0] terminal_value(
        input cnt_mode_e                mode,
        input logic [CNT_WIDTH_MAX-1:0] limit
    );
        return (mode == CNT_MODE_DOWN) ? '0 : limit;
    endfunction

endpackage

// File: rtl/cnt_bank_chan.sv
// One counter channel: holds its own limit and mode, counts on inc,
// and reports end/wrap/done status.
module cnt_bank_chan
    import cnt_bank_pkg::*;
#(
    parameter int CNT_WIDTH     = 6,
    parameter int DEFAULT_LIMIT = 39
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [CNT_WIDTH-1:0] cfg_limit,
    input  logic [1:0]           cfg_mode,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 cnt_end,
    output logic                 cnt_wrap,
    output logic                 cnt_done
);

    logic [CNT_WIDTH-1:0] limit;
    cnt_mode_e            mode;
    cnt_mode_e            new_mode;
    logic [CNT_WIDTH-1:0] cur_start;
    logic [CNT_WIDTH-1:0] cur_term;
    logic [CNT_WIDTH-1:0] new_start;

    assign new_mode  = cnt_mode_e'(cfg_mode);
    assign cur_start = CNT_WIDTH'(start_value(mode, CNT_WIDTH_MAX'(limit)));
    assign cur_term  = CNT_WIDTH'(terminal_value(mode, CNT_WIDTH_MAX'(limit)));
    assign new_start = CNT_WIDTH'(start_value(new_mode, CNT_WIDTH_MAX'(cfg_limit)));

    // End flag is purely a function of the registered count, limit and mode.
    assign cnt_end = (cnt == cur_term);

    // Counter state update; priority is reset, clear, config write, inc.
    // NOTE: every register here uses <= so all channel state moves together
    // on the edge and no read sees a half-updated value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            limit    <= CNT_WIDTH'(DEFAULT_LIMIT);
            mode     <= CNT_MODE_WRAP;
            cnt_wrap <= 1'b0;
            cnt_done <= 1'b0;
        end else begin
            // The wrap pulse lasts one cycle unless re-armed below.
            cnt_wrap <= 1'b0;
            if (clr) begin
                cnt      <= cur_start;
                cnt_done <= 1'b0;
            end else if (cfg_we) begin
                limit    <= cfg_limit;
                mode     <= new_mode;
                cnt      <= new_start;
                cnt_done <= 1'b0;
            end else if (inc) begin
                if (!cnt_end) begin
                    if (mode == CNT_MODE_DOWN) begin
                        cnt <= cnt - 1'b1;
                    end else if (!(mode == CNT_MODE_ONESHOT && cnt_done)) begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    case (mode)
                        CNT_MODE_WRAP: begin
                            cnt      <= '0;
                            cnt_wrap <= 1'b1;
                        end
                        CNT_MODE_ONESHOT: cnt_done <= 1'b1;
                        CNT_MODE_DOWN: begin
                            cnt      <= limit;
                            cnt_wrap <= 1'b1;
                        end
                        default: ; // SAT holds at the limit
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/cnt_bank.sv
// Bank of independent, runtime-configurable event counters. Decodes the
// configuration channel select and packs the per-channel outputs.
module cnt_bank
    import cnt_bank_pkg::*;
#(
    parameter  int CH_NUM        = 4,
    parameter  int CNT_WIDTH     = 6,
    parameter  int DEFAULT_LIMIT = 39,
    localparam int CH_W          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [CH_W-1:0]             cfg_ch,
    input  logic [CNT_WIDTH-1:0]        cfg_limit,
    input  logic [1:0]                  cfg_mode,
    input  logic [CH_NUM-1:0]           cnt_inc,
    input  logic [CH_NUM-1:0]           cnt_clr,
    output logic [CH_NUM*CNT_WIDTH-1:0] cnt,
    output logic [CH_NUM-1:0]           cnt_end,
    output logic [CH_NUM-1:0]           cnt_wrap,
    output logic [CH_NUM-1:0]           cnt_done
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        // A select beyond CH_NUM-1 matches no channel and is thus ignored.
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        cnt_bank_chan #(
            .CNT_WIDTH    (CNT_WIDTH),
            .DEFAULT_LIMIT(DEFAULT_LIMIT)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .cfg_we   (ch_we),
            .cfg_limit(cfg_limit),
            .cfg_mode (cfg_mode),
            .inc      (cnt_inc[i]),
            .clr      (cnt_clr[i]),
            .cnt      (cnt[i*CNT_WIDTH +: CNT_WIDTH]),
            .cnt_end  (cnt_end[i]),
            .cnt_wrap (cnt_wrap[i]),
            .cnt_done (cnt_done[i])
        );
    end

endmodule

// File: doc/cnt_bank.md
# cnt_bank

Multi-channel, runtime-configurable event counter bank that generalises the core's fixed-terminal wrap counter. Each of `CH_NUM` independent channels has its own software-loadable terminal value and counting mode: wrap, saturate, one-shot or down-reload. Typical uses are bit/beat counters in the serial and memory-side units and timeout timers in the core. All state is in the `clk` domain.

## Interface
Parameters:
- `CH_NUM`, 4, number of independent channels (1..16).
- `CNT_WIDTH`, 6, counter and limit width per channel.
- `DEFAULT_LIMIT`, 39, terminal value loaded into every channel at reset; must fit in `CNT_WIDTH`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `cfg_we` in 1: configuration write strobe.
- `cfg_ch` in `$clog2(CH_NUM)` (min 1): channel selected by `cfg_we`.
- `cfg_limit` in `CNT_WIDTH`: new terminal value.
- `cfg_mode` in 2: new mode (0 WRAP, 1 SAT, 2 ONESHOT, 3 DOWN).
- `cnt_inc` in `CH_NUM`: per-channel count-step request.
- `cnt_clr` in `CH_NUM`: per-channel restart.
- `cnt` out `CH_NUM*CNT_WIDTH`: current counts; channel i is at bits [i*CNT_WIDTH +: CNT_WIDTH].
- `cnt_end` out `CH_NUM`: combinational; channel is at its terminal value.
- `cnt_wrap` out `CH_NUM`: registered one-cycle pulse when a channel reloads from terminal to start.
- `cnt_done` out `CH_NUM`: sticky flag; ONESHOT channel has reached its terminal value.

## Operation
- Start value: 0 for WRAP, SAT and ONESHOT; `limit` for DOWN.
- Terminal value: `limit` for WRAP, SAT and ONESHOT; 0 for DOWN.
- `cnt_end[i]` = (`cnt[i]` == terminal), evaluated from registered state only.
- Per-channel priority, highest first: `reset` > `cnt_clr[i]` > config write to channel i > `cnt_inc[i]`.
- `reset`: all `cnt`=0, `limit`=`DEFAULT_LIMIT`, mode=WRAP, `cnt_wrap`=0, `cnt_done`=0.
- `cnt_clr[i]`: `cnt`←start value, `cnt_done`←0. A simultaneous `cnt_inc[i]` is dropped.
- Config write (`cfg_we` with `cfg_ch`==i, no clear): `limit` and mode are updated, and `cnt`←start value computed from the new limit and mode. `cnt_done`←0. A simultaneous `cnt_inc[i]` is dropped. A `cfg_ch` ≥ `CH_NUM` is ignored.
- `cnt_inc[i]` with the channel not at terminal: WRAP/SAT/ONESHOT `cnt`+1; DOWN `cnt`−1. ONESHOT with `cnt_done`=1 ignores inc.
- `cnt_inc[i]` with the channel at terminal:
  - WRAP: `cnt`←0, `cnt_wrap` pulses.
  - SAT: hold, no pulse.
  - ONESHOT: hold, `cnt_done`←1; no further counting until clear or config write.
  - DOWN: `cnt`←`limit`, `cnt_wrap` pulses.
- `limit`=0: in WRAP, every inc produces a wrap pulse with `cnt` staying 0. In DOWN, the channel reloads 0 each inc and pulses each inc.
- Arithmetic is `CNT_WIDTH`-bit unsigned. The counter never passes the terminal value, so no modular overflow occurs.
- Channels are fully independent; any combination of `cnt_inc` bits may be high in the same cycle.

## Timing
- All state updates on `posedge clk`. `cnt` reflects an inc one cycle after the inc is sampled.
- `cnt_end` is combinational from `cnt` and `limit`, with 0-cycle latency relative to `cnt`.
- `cnt_wrap[i]` is high for exactly the one cycle in which `cnt` first shows the reloaded start value. Back-to-back wraps (`limit`=0) hold it high continuously.
- `cnt_done[i]` rises in the cycle after the terminal-cycle inc.
- `reset` mid-count takes effect on the next edge and overrides every other input.

## Structure
- Package `cnt_bank_pkg`:
  - mode encoding constants `CNT_MODE_WRAP`/`SAT`/`ONESHOT`/`DOWN`, 2-bit;
  - a function returning start value given mode and limit.
- Sub-module `cnt_bank_chan`: one channel holding `limit`, mode, `cnt`, `cnt_wrap` and `cnt_done`, with scalar ports.
- `cnt_bank` instantiates `CH_NUM` copies in a generate loop, decodes `cfg_ch` into per-channel write enables, and packs the outputs.

## Test plan
- Reset defaults: after reset, apply 39 incs to ch0 → `cnt`=39, `cnt_end`=1; the 40th inc → `cnt`=0 with `cnt_wrap[0]` high for 1 cycle.
- SAT mode: configure ch1 with limit=5, mode SAT, then apply 10 incs → `cnt` stops at 5, `cnt_end`=1, `cnt_wrap` is never asserted.
- ONESHOT mode: configure ch2 with limit=3, apply 5 incs → `cnt`=3 and `cnt_done`=1 after the 4th inc; then clear → `cnt`=0, `cnt_done`=0.
- DOWN mode: configure ch3 with limit=2 (`cnt`=2), apply incs → 1, 0, 2 with a wrap pulse on the reload; limit=0 gives a continuous pulse.
- Collisions: `cnt_clr`, config write and `cnt_inc` on ch0 in the same cycle → clear wins, and the config is not applied. Config write plus inc → new start value, inc dropped. Out-of-range `cfg_ch` changes nothing.
- Channel independence: random incs on all channels alongside a mid-count `reset` → every channel matches the reference model, and all outputs equal their reset values on the cycle after `reset`.
